// File: rtl/mem_lsu_if.sv
// ---------------------------------------------------------------------------
// mem_lsu_if: data-bus bundle between the memory-access stage and data memory.
//   req   : bus request, held high for the whole transaction
//   we    : 1 = store, 0 = load
//   addr  : word-aligned byte address
//   sel   : byte enables, bit 3 = bits [31:24] = byte offset 0 (big-endian)
//   wdata : store data, lane-replicated
//   rdata : read data, valid while ack = 1
//   ack   : transaction completes this cycle
// master = the LSU side, slave = the memory side.
// ---------------------------------------------------------------------------
interface mem_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, sel, wdata, input rdata, ack);
    modport slave  (input req, we, addr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu: memory-access stage of a 5-stage MIPS pipeline.
// Non-memory results pass through in one cycle. Loads/stores run one
// request/acknowledge transaction on the data bus with big-endian byte lanes,
// stalling the pipeline while outstanding; a request with no ack for TIMEOUT
// cycles is aborted with a bus-error pulse.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   valid_i, mem_op_i        instruction present, memory op code (0 = none)
//   mem_addr_i, store_data_i effective address, store data (rt)
//   wd_i, wreg_i, wdata_i    destination index, write enable, EX result
//   mem                      data-bus master (see mem_lsu_if)
//   stallreq_o               combinational stall request
//   valid_o, wd_o, wreg_o, wdata_o  registered result toward MEM/WB
//   addr_err_o, bus_err_o    one-cycle error pulses
// ---------------------------------------------------------------------------
module mem_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [3:0]       mem_op_i,
    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      store_data_i,
    input  logic [4:0]       wd_i,
    input  logic             wreg_i,
    input  logic [31:0]      wdata_i,
    mem_lsu_if.master        mem,
    output logic             stallreq_o,
    output logic             valid_o,
    output logic [4:0]       wd_o,
    output logic             wreg_o,
    output logic [31:0]      wdata_o,
    output logic             addr_err_o,
    output logic             bus_err_o
);
    typedef enum logic {S_IDLE, S_REQ} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           req_q, req_d, we_q, we_d;
    logic [31:0]    addr_q, addr_d, data_q, data_d;
    logic [3:0]     sel_q, sel_d;
    logic [3:0]     op_q, op_d;
    logic [1:0]     off_q, off_d;
    logic [4:0]     lwd_q, lwd_d;
    logic           lwreg_q, lwreg_d;
    logic           valid_q, valid_d, wreg_q, wreg_d;
    logic [4:0]     wd_q, wd_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           addr_err_q, addr_err_d, bus_err_q, bus_err_d;

    // Op decode: access size, bus lanes and store data for the incoming op.
    logic        is_byte, is_half, is_word, is_mem, is_store, aligned, start;
    logic [3:0]  sel_in;
    logic [31:0] sdata_in;

    always_comb begin
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (mem_op_i)
            4'd1, 4'd2, 4'd6: is_byte = 1'b1;
            4'd3, 4'd4, 4'd7: is_half = 1'b1;
            4'd5, 4'd8:       is_word = 1'b1;
            default:          ;
        endcase
        is_mem   = is_byte | is_half | is_word;
        is_store = (mem_op_i >= 4'd6) && (mem_op_i <= 4'd8);
        aligned  = !(is_half && mem_addr_i[0]) && !(is_word && (mem_addr_i[1:0] != 2'b00));
        sel_in   = 4'b1111;
        sdata_in = store_data_i;
        if (is_byte) begin
            sel_in   = 4'b1000 >> mem_addr_i[1:0];
            sdata_in = {4{store_data_i[7:0]}};
        end else if (is_half) begin
            sel_in   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            sdata_in = {2{store_data_i[15:0]}};
        end
    end

    // Read data split into big-endian byte lanes: lane 0 is bits [31:24].
    logic [7:0] lane [4];
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = mem.rdata[31-8*gi -: 8];
        end
    endgenerate

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        ld_byte = lane[off_q];
        ld_half = off_q[1] ? {lane[2], lane[3]} : {lane[0], lane[1]};
        case (op_q)
            4'd1:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            4'd2:    ld_ext = {24'd0, ld_byte};
            4'd3:    ld_ext = {{16{ld_half[15]}}, ld_half};
            4'd4:    ld_ext = {16'd0, ld_half};
            4'd5:    ld_ext = mem.rdata;
            default: ld_ext = 32'd0;
        endcase
    end

    // start is gated by rst so the stall request drops at once during reset
    // even if upstream keeps presenting a memory op.
    always_comb begin
        start      = !rst && (state_q == S_IDLE) && valid_i && is_mem && aligned;
        stallreq_o = start || ((state_q == S_REQ) && !mem.ack && (cnt_q != CNT_MAX));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        sel_d      = sel_q;
        op_d       = op_q;
        off_d      = off_q;
        lwd_d      = lwd_q;
        lwreg_d    = lwreg_q;
        wd_d       = wd_q;
        wdata_d    = wdata_q;
        valid_d    = 1'b0;
        wreg_d     = 1'b0;
        addr_err_d = 1'b0;
        bus_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    // counter = number of cycles the request has been high,
                    // including the current one
                    cnt_d   = CW'(1);
                    we_d    = is_store;
                    addr_d  = {mem_addr_i[31:2], 2'b00};
                    sel_d   = sel_in;
                    data_d  = sdata_in;
                    op_d    = mem_op_i;
                    off_d   = mem_addr_i[1:0];
                    lwd_d   = wd_i;
                    lwreg_d = wreg_i;
                end else begin
                    valid_d = valid_i;
                    wd_d    = wd_i;
                    if (valid_i && is_mem) begin
                        addr_err_d = 1'b1;
                        wdata_d    = 32'd0;
                    end else begin
                        wreg_d  = valid_i & wreg_i;
                        wdata_d = wdata_i;
                    end
                end
            end
            S_REQ: begin
                if (mem.ack) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    wd_d    = lwd_q;
                    wreg_d  = lwreg_q;
                    wdata_d = we_q ? 32'd0 : ld_ext;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    req_d     = 1'b0;
                    valid_d   = 1'b1;
                    bus_err_d = 1'b1;
                    wd_d      = lwd_q;
                    wdata_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            sel_q      <= 4'd0;
            op_q       <= 4'd0;
            off_q      <= 2'd0;
            lwd_q      <= 5'd0;
            lwreg_q    <= 1'b0;
            valid_q    <= 1'b0;
            wd_q       <= 5'd0;
            wreg_q     <= 1'b0;
            wdata_q    <= 32'd0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            op_q       <= op_d;
            off_q      <= off_d;
            lwd_q      <= lwd_d;
            lwreg_q    <= lwreg_d;
            valid_q    <= valid_d;
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            addr_err_q <= addr_err_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign mem.req    = req_q;
    assign mem.we     = we_q;
    assign mem.addr   = addr_q;
    assign mem.sel    = sel_q;
    assign mem.wdata  = data_q;
    assign valid_o    = valid_q;
    assign wd_o       = wd_q;
    assign wreg_o     = wreg_q;
    assign wdata_o    = wdata_q;
    assign addr_err_o = addr_err_q;
    assign bus_err_o  = bus_err_q;
endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i, store_data_i, wdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        stallreq_o, valid_o, wreg_o, addr_err_o, bus_err_o;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o;

    int checks = 0;
    int errors = 0;

    mem_lsu_if bus();

    mem_lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
        .store_data_i(store_data_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .mem(bus),
        .stallreq_o(stallreq_o), .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .addr_err_o(addr_err_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model (from the op rules) ----------------
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [3:0] m_sel(input int sz, input logic [31:0] addr);
        int off, m;
        off = int'(addr[1:0]);
        m = ((1 << sz) - 1) << (4 - sz - off);
        return 4'(m);
    endfunction

    function automatic logic [31:0] m_store(input int sz, input logic [31:0] d);
        if (sz == 1) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input int sz,
                                           input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] v, mask;
        int off;
        off  = int'(addr[1:0]);
        mask = (sz == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * sz)) - 32'h1);
        v    = (rd >> (8 * (4 - sz - off))) & mask;
        if ((op == 4'd1 || op == 4'd3) && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // Runs one instruction starting at the current negedge; returns at the
    // negedge where its result is visible (inputs there already back to bubble).
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int ack_k, input logic [4:0] wd,
                         input logic wreg, input logic [31:0] wdata,
                         output logic [3:0] got_sel, output logic [31:0] got_mdata,
                         output logic [31:0] got_res);
        int sz, stalls;
        bit is_mem, ok, st, acked, exp_stall;
        sz     = op_size(op);
        is_mem = (sz != 0);
        ok     = is_mem && ((int'(addr[1:0]) % sz) == 0);
        st     = (op >= 4'd6) && (op <= 4'd8);
        acked  = 0;
        got_sel = 4'd0;
        got_mdata = 32'd0;
        valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; store_data_i = sdata;
        wd_i = wd; wreg_i = wreg; wdata_i = wdata;
        #1;
        chk("stall_c0", stallreq_o, ok);
        chk("req_c0", bus.req, 1'b0);
        if (ok) begin
            stalls = 1;
            for (int c = 1; c <= TIMEOUT; c++) begin
                @(negedge clk);
                chk("req_hi", bus.req, 1'b1);
                chk("bus_sel", bus.sel, m_sel(sz, addr));
                chk("bus_addr", bus.addr, addr & 32'hFFFFFFFC);
                chk("bus_we", bus.we, st);
                if (st) chk("bus_wdata", bus.wdata, m_store(sz, sdata));
                got_sel = bus.sel;
                got_mdata = bus.wdata;
                if (c == ack_k) begin
                    bus.ack = 1'b1;
                    bus.rdata = rdata;
                    acked = 1;
                end
                #1;
                exp_stall = !acked && (c != TIMEOUT);
                chk("stall_req", stallreq_o, exp_stall);
                if (stallreq_o) stalls++;
                if (acked) break;
            end
            @(negedge clk);
            bus.ack = 1'b0;
            bus.rdata = $urandom;
            chk("res_valid", valid_o, 1'b1);
            chk("res_req_lo", bus.req, 1'b0);
            chk("res_bus_err", bus_err_o, !acked);
            chk("res_addr_err", addr_err_o, 1'b0);
            chk("res_wd", wd_o, wd);
            chk("res_wreg", wreg_o, acked ? wreg : 1'b0);
            chk("res_wdata", wdata_o, (acked && !st) ? m_load(op, sz, addr, rdata) : 32'd0);
            if (acked) chk("stall_cycles", 32'(stalls), 32'(ack_k));
        end else begin
            @(negedge clk);
            chk("res_valid", valid_o, 1'b1);
            chk("res_req_lo", bus.req, 1'b0);
            chk("res_addr_err", addr_err_o, is_mem);
            chk("res_bus_err", bus_err_o, 1'b0);
            chk("res_wreg", wreg_o, is_mem ? 1'b0 : wreg);
            if (!is_mem) begin
                chk("res_wd", wd_o, wd);
                chk("res_wdata", wdata_o, wdata);
            end
        end
        got_res = wdata_o;
        $display("TXN op=%0d addr=%h ack_k=%0d sel=%b wdata_o=%h wreg_o=%0d addr_err=%0d bus_err=%0d",
                 op, addr, ack_k, got_sel, wdata_o, wreg_o, addr_err_o, bus_err_o);
        valid_i = 1'b0;
        mem_op_i = 4'd0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr, sdata, rdata;
        int          ack_k;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        bit          chk_bus;
        logic [3:0]  exp_sel;
        logic [31:0] exp_mdata;
        bit          chk_res;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [3:0]  gs;
        logic [31:0] gm, gr;

        vecs[0] = '{4'd0, 32'h0, 32'h0, 32'h0, 1, 5'd5, 1'b1, 32'h1234, 0, 4'h0, 32'h0, 1, 32'h1234};
        vecs[1] = '{4'd1, 32'h1003, 32'h0, 32'h000000F0, 3, 5'd7, 1'b1, 32'h0, 1, 4'b0001, 32'h0, 1, 32'hFFFFFFF0};
        vecs[2] = '{4'd2, 32'h1003, 32'h0, 32'h000000F0, 3, 5'd7, 1'b1, 32'h0, 1, 4'b0001, 32'h0, 1, 32'h000000F0};
        vecs[3] = '{4'd4, 32'h1002, 32'h0, 32'h0000ABCD, 2, 5'd8, 1'b1, 32'h0, 1, 4'b0011, 32'h0, 1, 32'h0000ABCD};
        vecs[4] = '{4'd7, 32'h2000, 32'h89AB, 32'h0, 1, 5'd0, 1'b0, 32'h0, 1, 4'b1100, 32'h89AB89AB, 1, 32'h0};
        vecs[5] = '{4'd5, 32'h3002, 32'h0, 32'h0, 1, 5'd9, 1'b1, 32'h0, 0, 4'h0, 32'h0, 0, 32'h0};
        vecs[6] = '{4'd3, 32'h4000, 32'h0, 32'h8001FFFF, 1, 5'd3, 1'b1, 32'h0, 1, 4'b1100, 32'h0, 1, 32'hFFFF8001};

        rst = 1'b1; valid_i = 1'b0; mem_op_i = 4'd0; mem_addr_i = 32'd0; store_data_i = 32'd0;
        wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'd0; bus.ack = 1'b0; bus.rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_req", bus.req, 1'b0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_stall", stallreq_o, 1'b0);
        rst = 1'b0;

        // bubble: no result, no write
        wreg_i = 1'b1;
        @(negedge clk);
        chk("bubble_valid", valid_o, 1'b0);
        chk("bubble_wreg", wreg_o, 1'b0);

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].rdata, vecs[i].ack_k,
                  vecs[i].wd, vecs[i].wreg, vecs[i].wdata, gs, gm, gr);
            if (vecs[i].chk_bus) begin
                chk("tbl_sel", gs, vecs[i].exp_sel);
                if (vecs[i].op >= 4'd6) chk("tbl_mdata", gm, vecs[i].exp_mdata);
            end
            if (vecs[i].chk_res) chk("tbl_res", gr, vecs[i].exp_res);
            @(negedge clk);
        end

        // back-to-back: SW presented the cycle the LW result appears
        do_op(4'd5, 32'h5000, 32'h0, 32'hCAFEF00D, 2, 5'd4, 1'b1, 32'h0, gs, gm, gr);
        do_op(4'd8, 32'h5004, 32'h11223344, 32'h0, 1, 5'd0, 1'b0, 32'h0, gs, gm, gr);

        // timeout with a late ack
        do_op(4'd5, 32'h6000, 32'h0, 32'h0, TIMEOUT + 1, 5'd6, 1'b1, 32'h0, gs, gm, gr);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        chk("late_ack_req", bus.req, 1'b0);
        chk("late_ack_valid", valid_o, 1'b0);
        chk("late_ack_bus_err", bus_err_o, 1'b0);

        // reset in the middle of a request
        valid_i = 1'b1; mem_op_i = 4'd5; mem_addr_i = 32'h7000; wd_i = 5'd2; wreg_i = 1'b1;
        @(negedge clk);
        chk("mid_req_hi", bus.req, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req", bus.req, 1'b0);
        chk("mid_rst_stall", stallreq_o, 1'b0);
        chk("mid_rst_sel", bus.sel, 4'd0);
        chk("mid_rst_valid", valid_o, 1'b0);
        valid_i = 1'b0; mem_op_i = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req", bus.req, 1'b0);
        chk("post_rst_valid", valid_o, 1'b0);

        // randomized ops against the model
        for (int n = 0; n < 60; n++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 15));
            do_op(rop, $urandom, $urandom, $urandom, $urandom_range(1, TIMEOUT + 1),
                  5'($urandom), 1'($urandom), $urandom, gs, gm, gr);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
